// File: rtl/tl45_isa_pkg.sv
// TL45 ISA definitions shared by decode and later stages: opcodes, instruction
// field positions, FSM state encoding, the decode-buffer record and the legal-opcode check.
package tl45_isa_pkg;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,
    OP_ADD  = 5'd1,
    OP_SUB  = 5'd2,
    OP_MUL  = 5'd3,
    OP_DIV  = 5'd4,
    OP_AND  = 5'd5,
    OP_OR   = 5'd6,
    OP_XOR  = 5'd7,
    OP_SHL  = 5'd8,
    OP_SHR  = 5'd9,
    OP_JMP  = 5'd12,
    OP_CALL = 5'd13,
    OP_LD   = 5'd14,
    OP_ST   = 5'd15
  } opcode_e;

  localparam int OPC_HI       = 31;
  localparam int OPC_LO       = 27;
  localparam int IMM_FLAG_BIT = 26;
  localparam int HI_SHIFT_BIT = 25;
  localparam int SEXT_BIT     = 24;
  localparam int DR_HI        = 23;
  localparam int DR_LO        = 20;
  localparam int SR1_HI       = 19;
  localparam int SR1_LO       = 16;
  localparam int SR2_HI       = 15;
  localparam int SR2_LO       = 12;
  localparam int IMM16_HI     = 15;
  localparam int IMM16_LO     = 0;

  localparam logic [3:0] COND_ALWAYS = 4'hF;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } dec_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  opcode;
    logic [3:0]  dr;
    logic [3:0]  sr1;
    logic [3:0]  sr2;
    logic [31:0] imm;
    logic        imm_valid;
  } dec_buf_t;

  // Opcodes 10, 11 and 16..31 are unassigned.
  function automatic logic is_legal_op(input logic [4:0] op);
    return (op <= 5'd9) || (op[4:2] == 3'b011);
  endfunction

endpackage

// File: rtl/tl45_decode_if.sv
// Fetch <-> decode link: the fetch buffer flowing in, and the stall/flush/PC-override
// controls flowing back. Levels only; no handshake beyond the stall.
interface tl45_decode_if;
  logic [31:0] i_buf_pc;
  logic [31:0] i_buf_inst;
  logic        o_fetch_stall;
  logic        o_fetch_flush;
  logic        o_fetch_new_pc;
  logic [31:0] o_fetch_pc;

  modport master (
    output i_buf_pc, i_buf_inst,
    input  o_fetch_stall, o_fetch_flush, o_fetch_new_pc, o_fetch_pc
  );

  modport slave (
    input  i_buf_pc, i_buf_inst,
    output o_fetch_stall, o_fetch_flush, o_fetch_new_pc, o_fetch_pc
  );
endinterface

// File: rtl/tl45_imm_ext.sv
// Combinational immediate extender: high-shift, sign-extend or zero-extend of imm16.
module tl45_imm_ext (
  input  logic [15:0] imm16_i,
  input  logic        hi_shift_i,
  input  logic        sext_i,
  output logic [31:0] imm_o
);
  always_comb begin
    if (hi_shift_i) begin
      imm_o = {imm16_i, 16'h0000};
    end else if (sext_i) begin
      imm_o = {{16{imm16_i[15]}}, imm16_i};
    end else begin
      imm_o = {16'h0000, imm16_i};
    end
  end
endmodule

// File: rtl/tl45_decode.sv
// TL45 decode stage: registers decoded fields, redirects fetch on absolute jumps and
// halts on illegal opcodes. TL45_DECODE_PERF_EN adds instruction/redirect counters.
module tl45_decode
  import tl45_isa_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_stall,
  input  logic        i_pipe_flush,
  input  logic        i_new_pc,
  input  logic [31:0] i_pc,
  tl45_decode_if.slave fetch,
  output logic [31:0] o_buf_pc,
  output logic [4:0]  o_buf_opcode,
  output logic [3:0]  o_buf_dr,
  output logic [3:0]  o_buf_sr1,
  output logic [3:0]  o_buf_sr2,
  output logic [31:0] o_buf_imm,
  output logic        o_buf_imm_valid,
  output logic        o_halted
`ifdef TL45_DECODE_PERF_EN
  ,
  output logic [31:0] o_perf_inst_cnt,
  output logic [31:0] o_perf_redir_cnt
`endif
);

  localparam dec_buf_t BUF_RESET = '{pc: RESET_PC, default: '0};

  dec_state_e  state_q, state_d;
  dec_buf_t    buf_q, buf_d, dec;
  logic [31:0] inst;
  logic [15:0] imm16;
  logic [31:0] imm_ext;
  logic        imm_flag;
  logic        halted;
  logic        jmp_abs;
  logic        redirect;
  logic        latch_en;

  assign inst     = fetch.i_buf_inst;
  assign imm16    = inst[IMM16_HI:IMM16_LO];
  assign imm_flag = inst[IMM_FLAG_BIT];

  tl45_imm_ext u_imm_ext (
    .imm16_i   (imm16),
    .hi_shift_i(inst[HI_SHIFT_BIT]),
    .sext_i    (inst[SEXT_BIT]),
    .imm_o     (imm_ext)
  );

  always_comb begin
    dec.pc        = fetch.i_buf_pc;
    dec.opcode    = inst[OPC_HI:OPC_LO];
    dec.dr        = inst[DR_HI:DR_LO];
    dec.sr1       = inst[SR1_HI:SR1_LO];
    dec.sr2       = imm_flag ? 4'h0 : inst[SR2_HI:SR2_LO];
    dec.imm       = imm_ext;
    dec.imm_valid = imm_flag;
  end

  assign halted   = (state_q == S_HALT);
  assign jmp_abs  = (dec.opcode == OP_JMP) && (dec.dr == COND_ALWAYS) &&
                    (dec.sr1 == 4'h0) && imm_flag;
  assign redirect = !halted && !i_pipe_stall && !i_pipe_flush && jmp_abs;

  // Flush beats everything (including a same-cycle illegal opcode); stall/HALT hold.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    latch_en = 1'b0;
    if (i_pipe_flush) begin
      state_d = S_RUN;
      buf_d   = BUF_RESET;
    end else if (!i_pipe_stall && !halted) begin
      latch_en = 1'b1;
      if (redirect) begin
        buf_d    = '0;
        buf_d.pc = fetch.i_buf_pc;
      end else begin
        buf_d = dec;
        if (!is_legal_op(dec.opcode)) begin
          state_d = S_HALT;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_RUN;
      buf_q   <= BUF_RESET;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  // A downstream override always takes the PC mux over the early jump target.
  assign fetch.o_fetch_stall  = i_pipe_stall | halted;
  assign fetch.o_fetch_flush  = i_pipe_flush | redirect;
  assign fetch.o_fetch_new_pc = i_new_pc | redirect;
  assign fetch.o_fetch_pc     = i_new_pc ? i_pc : {{14{imm16[15]}}, imm16, 2'b00};

  assign o_buf_pc        = buf_q.pc;
  assign o_buf_opcode    = buf_q.opcode;
  assign o_buf_dr        = buf_q.dr;
  assign o_buf_sr1       = buf_q.sr1;
  assign o_buf_sr2       = buf_q.sr2;
  assign o_buf_imm       = buf_q.imm;
  assign o_buf_imm_valid = buf_q.imm_valid;
  assign o_halted        = halted;

`ifdef TL45_DECODE_PERF_EN
  logic [31:0] inst_cnt_q;
  logic [31:0] redir_cnt_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      inst_cnt_q  <= 32'h0;
      redir_cnt_q <= 32'h0;
    end else begin
      if (latch_en && !redirect && (inst != 32'h0)) begin
        inst_cnt_q <= inst_cnt_q + 32'd1;
      end
      if (redirect) begin
        redir_cnt_q <= redir_cnt_q + 32'd1;
      end
    end
  end

  assign o_perf_inst_cnt  = inst_cnt_q;
  assign o_perf_redir_cnt = redir_cnt_q;
`endif

endmodule
